// File: rtl/dff.sv
// -----------------------------------------------------------------------------
// dff -- WIDTH-bit D flip-flop with asynchronous active-high reset and a
//        complemented output.
//
// Parameters
//   WIDTH    data width in bits (1..64)
//   RST_VAL  value forced onto q while reset is asserted
//
// Ports
//   clk    in   1      clock; d is captured on the rising edge
//   rst_   in   1      asynchronous reset, active-high
//   d      in   WIDTH  data input
//   q      out  WIDTH  registered data
//   q_bar  out  WIDTH  bitwise complement of q (combinational from the register)
// -----------------------------------------------------------------------------
module dff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    // The only state element in the block.
    logic [WIDTH-1:0] r_q;

    // Capture d on every rising edge; reset overrides immediately and holds
    // the register at RST_VAL for as long as rst_ stays high.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= d;
        end
    end

    // q_bar is derived from the register itself, so it tracks q with no
    // extra clock delay, including while reset is held.
    assign q     = r_q;
    assign q_bar = ~r_q;

endmodule

// File: tb/tb_dff.sv
`timescale 1ns/1ps
module tb_dff;

    logic       clk;
    logic       rst1;
    logic       d1;
    logic       q1;
    logic       qb1;

    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qb8;

    int n_checks;
    int n_fail;

    dff u_dut1 (
        .clk   (clk),
        .rst_  (rst1),
        .d     (d1),
        .q     (q1),
        .q_bar (qb1)
    );

    dff #(
        .WIDTH   (8),
        .RST_VAL (8'h3C)
    ) u_dut8 (
        .clk   (clk),
        .rst_  (rst8),
        .d     (d8),
        .q     (q8),
        .q_bar (qb8)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_until(input realtime t);
        if (t > $realtime) #(t - $realtime);
    endtask

    // Reset asserted between edges takes effect at once.
    task automatic test_reset;
        rst1 = 1'b0;
        d1   = 1'b1;
        wait_until(4.0);
        rst1 = 1'b1;
        wait_until(4.1);
        n_checks++;
        if (q1 !== 1'b0 || qb1 !== 1'b1) begin
            $display("FAIL async_assert: q=%b q_bar=%b, required q=0 q_bar=1", q1, qb1);
            n_fail++;
        end
    endtask

    // d changes and clock edges while in reset leave q at the reset value.
    task automatic test_hold_in_reset;
        wait_until(6.0);
        n_checks++;
        if (q1 !== 1'b0 || qb1 !== 1'b1) begin
            $display("FAIL hold_edge5: q=%b q_bar=%b, required q=0 q_bar=1", q1, qb1);
            n_fail++;
        end
        wait_until(7.0);
        d1 = 1'b0;
        wait_until(12.0);
        d1 = 1'b1;
        wait_until(12.1);
        n_checks++;
        if (q1 !== 1'b0 || qb1 !== 1'b1) begin
            $display("FAIL hold_dchange: q=%b q_bar=%b, required q=0 q_bar=1", q1, qb1);
            n_fail++;
        end
        wait_until(16.0);
        n_checks++;
        if (q1 !== 1'b0 || qb1 !== 1'b1) begin
            $display("FAIL hold_edge15: q=%b q_bar=%b, required q=0 q_bar=1", q1, qb1);
            n_fail++;
        end
    endtask

    // After release q holds until the next rising edge, then loads d.
    task automatic test_release;
        wait_until(18.0);
        rst1 = 1'b0;
        d1   = 1'b1;
        wait_until(18.1);
        n_checks++;
        if (q1 !== 1'b0) begin
            $display("FAIL release_hold: q=%b, required 0", q1);
            n_fail++;
        end
        // falling edge at t=20 must not load d
        wait_until(20.1);
        n_checks++;
        if (q1 !== 1'b0 || qb1 !== 1'b1) begin
            $display("FAIL release_negedge: q=%b q_bar=%b, required q=0 q_bar=1", q1, qb1);
            n_fail++;
        end
        wait_until(26.0);
        n_checks++;
        if (q1 !== 1'b1 || qb1 !== 1'b0) begin
            $display("FAIL release_load: q=%b q_bar=%b, required q=1 q_bar=0", q1, qb1);
            n_fail++;
        end
    endtask

    // q follows d one edge later and ignores d between edges.
    task automatic test_data_follow;
        wait_until(28.0);
        d1 = 1'b0;
        wait_until(29.0);
        n_checks++;
        if (q1 !== 1'b1) begin
            $display("FAIL follow_hold: q=%b, required 1", q1);
            n_fail++;
        end
        wait_until(30.1);
        n_checks++;
        if (q1 !== 1'b1 || qb1 !== 1'b0) begin
            $display("FAIL follow_negedge: q=%b q_bar=%b, required q=1 q_bar=0", q1, qb1);
            n_fail++;
        end
        wait_until(36.0);
        n_checks++;
        if (q1 !== 1'b0 || qb1 !== 1'b1) begin
            $display("FAIL follow_load: q=%b q_bar=%b, required q=0 q_bar=1", q1, qb1);
            n_fail++;
        end
    endtask

    // Reset mid-cycle overrides a non-reset q, then holds across an edge.
    task automatic test_mid_cycle_override;
        wait_until(40.0);
        d1 = 1'b1;
        wait_until(46.0);
        n_checks++;
        if (q1 !== 1'b1) begin
            $display("FAIL override_setup: q=%b, required 1", q1);
            n_fail++;
        end
        wait_until(48.0);
        rst1 = 1'b1;
        wait_until(48.1);
        n_checks++;
        if (q1 !== 1'b0 || qb1 !== 1'b1) begin
            $display("FAIL override_async: q=%b q_bar=%b, required q=0 q_bar=1", q1, qb1);
            n_fail++;
        end
        wait_until(56.0);
        n_checks++;
        if (q1 !== 1'b0) begin
            $display("FAIL override_hold_edge: q=%b, required 0", q1);
            n_fail++;
        end
        wait_until(58.0);
        rst1 = 1'b0;
        wait_until(64.0);
        n_checks++;
        if (q1 !== 1'b0) begin
            $display("FAIL override_release_hold: q=%b, required 0", q1);
            n_fail++;
        end
        wait_until(66.0);
        n_checks++;
        if (q1 !== 1'b1 || qb1 !== 1'b0) begin
            $display("FAIL override_release_load: q=%b q_bar=%b, required q=1 q_bar=0", q1, qb1);
            n_fail++;
        end
    endtask

    // New d every cycle, driven at the falling edge, loaded at each rising edge.
    task automatic test_back_to_back;
        logic [3:0] pat;
        pat = 4'b0110;  // applied LSB first: 0,1,1,0
        for (int i = 0; i < 4; i++) begin
            wait_until(70.0 + 10.0 * i);
            d1 = pat[i];
            wait_until(76.0 + 10.0 * i);
            n_checks++;
            if (q1 !== pat[i] || qb1 !== ~pat[i]) begin
                $display("FAIL back_to_back[%0d]: q=%b q_bar=%b, required q=%b q_bar=%b",
                         i, q1, qb1, pat[i], ~pat[i]);
                n_fail++;
            end
        end
    endtask

    // 8-bit instance with a non-zero reset value.
    task automatic test_width_rstval;
        wait_until(110.0);
        d8   = 8'hFF;
        rst8 = 1'b1;
        wait_until(110.1);
        n_checks++;
        if (q8 !== 8'h3C || qb8 !== 8'hC3) begin
            $display("FAIL w8_reset: q=%h q_bar=%h, required q=3c q_bar=c3", q8, qb8);
            n_fail++;
        end
        wait_until(116.0);
        n_checks++;
        if (q8 !== 8'h3C) begin
            $display("FAIL w8_reset_hold: q=%h, required 3c", q8);
            n_fail++;
        end
        wait_until(118.0);
        rst8 = 1'b0;
        d8   = 8'hA5;
        wait_until(124.0);
        n_checks++;
        if (q8 !== 8'h3C) begin
            $display("FAIL w8_release_hold: q=%h, required 3c", q8);
            n_fail++;
        end
        wait_until(126.0);
        n_checks++;
        if (q8 !== 8'hA5 || qb8 !== 8'h5A) begin
            $display("FAIL w8_load: q=%h q_bar=%h, required q=a5 q_bar=5a", q8, qb8);
            n_fail++;
        end
        wait_until(130.0);
        d8 = 8'h5A;
        wait_until(136.0);
        n_checks++;
        if (q8 !== 8'h5A || qb8 !== 8'hA5) begin
            $display("FAIL w8_load2: q=%h q_bar=%h, required q=5a q_bar=a5", q8, qb8);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst8     = 1'b0;
        d8       = 8'h00;
        test_reset();
        test_hold_in_reset();
        test_release();
        test_data_follow();
        test_mid_cycle_override();
        test_back_to_back();
        test_width_rstval();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
